// File: rtl/dht11_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Package : dht11_pkg
//  Shared DHT-11 protocol definitions: FSM state encoding, protocol timing
//  (in microseconds), frame length and the frame checksum helper.
//  Revision: 1.0  initial release
// ============================================================================
package dht11_pkg;

   // Responder FSM states
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START_LOW = 3'd1,
      WAIT_REL  = 3'd2,
      RESP_L    = 3'd3,
      RESP_H    = 3'd4,
      BIT_L     = 3'd5,
      BIT_H     = 3'd6,
      END_L     = 3'd7
   } dht_state_t;

   // Protocol timing shared with the dht11_top master (microseconds)
   localparam int DHT_START_MIN_US  = 18000;
   localparam int DHT_RESP_DLY_US   = 30;
   localparam int DHT_RESP_US       = 80;
   localparam int DHT_BIT_LOW_US    = 50;
   localparam int DHT_BIT0_HIGH_US  = 26;
   localparam int DHT_BIT1_HIGH_US  = 70;

   localparam int FRAME_BITS = 40;
   // Wide enough for DHT_START_MIN_US (max 32767)
   localparam int US_CNT_W   = 15;

   // Frame checksum: byte-wise sum modulo 256
   function automatic logic [7:0] dht_checksum(input logic [7:0] a,
                                               input logic [7:0] b,
                                               input logic [7:0] c,
                                               input logic [7:0] d);
      return a + b + c + d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tick_gen_us.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : tick_gen_us
//  One-cycle tick every microsecond. 'clear' restarts the phase so the first
//  tick after a clear arrives exactly CLK_FREQ/1e6 cycles later.
//  Revision: 1.0  initial release
// ============================================================================
module tick_gen_us #(
   parameter int CLK_FREQ = 100_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int DIV = (CLK_FREQ / 1_000_000 < 1) ? 1 : CLK_FREQ / 1_000_000;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   // Cycle counter within the current microsecond; restarts on clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clear || cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   // Tick does not look at clear, so the caller may derive clear from tick
   assign tick = (cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/dht11_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : dht11_responder
//  DHT-11 sensor emulator: detects the host start pulse, answers with the
//  response handshake and sends a latched 40-bit frame MSB first on an
//  open-drain line.
//  Revision: 1.0  initial release
// ============================================================================
module dht11_responder
   import dht11_pkg::*;
#(
   parameter int CLK_FREQ     = 100_000_000,
   parameter int START_MIN_US = DHT_START_MIN_US,
   parameter int RESP_DLY_US  = DHT_RESP_DLY_US,
   parameter int RESP_US      = DHT_RESP_US,
   parameter int BIT_LOW_US   = DHT_BIT_LOW_US,
   parameter int BIT0_HIGH_US = DHT_BIT0_HIGH_US,
   parameter int BIT1_HIGH_US = DHT_BIT1_HIGH_US
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [7:0] hum_int,
   input  logic [7:0] hum_dec,
   input  logic [7:0] tmp_int,
   input  logic [7:0] tmp_dec,
   input  logic       inject_err,
   inout  wire        dht_io,
   output logic       busy,
   output logic       frame_done
);

   localparam logic [US_CNT_W-1:0] START_MIN_C = US_CNT_W'(START_MIN_US);
   localparam logic [US_CNT_W-1:0] RESP_DLY_C  = US_CNT_W'(RESP_DLY_US);
   localparam logic [US_CNT_W-1:0] RESP_C      = US_CNT_W'(RESP_US);
   localparam logic [US_CNT_W-1:0] BIT_LOW_C   = US_CNT_W'(BIT_LOW_US);
   localparam logic [US_CNT_W-1:0] BIT0_C      = US_CNT_W'(BIT0_HIGH_US);
   localparam logic [US_CNT_W-1:0] BIT1_C      = US_CNT_W'(BIT1_HIGH_US);
   localparam logic [5:0]          LAST_BIT    = 6'(FRAME_BITS - 1);

   dht_state_t            state;
   logic [1:0]            sync_q;
   logic                  line_hi;
   logic                  oe;
   logic                  armed;
   logic [US_CNT_W-1:0]   us_cnt;
   logic [US_CNT_W-1:0]   phase_len;
   logic [FRAME_BITS-1:0] shreg;
   logic [5:0]            bit_idx;
   logic                  tick;
   logic                  phase_done;
   logic                  start_ok;
   logic                  leave;

   tick_gen_us #(
      .CLK_FREQ(CLK_FREQ)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clear(leave),
      .tick (tick)
   );

   // Open-drain drive: only the enable is registered, the value is always 0
   assign dht_io = oe ? 1'b0 : 1'bz;

   // Two-flop synchroniser on the line; idles high like the pulled-up bus
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sync_q <= 2'b11;
      else
         sync_q <= {sync_q[0], dht_io};
   end

   assign line_hi = sync_q[1];

   // Length of the timed phase of the current state, in microseconds
   always_comb begin
      phase_len = RESP_C;
      case (state)
         WAIT_REL: phase_len = RESP_DLY_C;
         RESP_L,
         RESP_H:   phase_len = RESP_C;
         BIT_L,
         END_L:    phase_len = BIT_LOW_C;
         BIT_H:    phase_len = shreg[FRAME_BITS-1] ? BIT1_C : BIT0_C;
         default:  phase_len = RESP_C;
      endcase
   end

   assign phase_done = tick && (us_cnt == phase_len - 1'b1);

   // The IDLE cycle that saw the falling edge was low time too, so the
   // microsecond completing in this cycle is counted before comparing.
   assign start_ok = (us_cnt == START_MIN_C) ||
                     (tick && us_cnt == START_MIN_C - 1'b1);

   // Every state change restarts the tick phase and the microsecond counter
   always_comb begin
      leave = 1'b0;
      if (!enable)
         leave = (state != IDLE);
      else begin
         case (state)
            IDLE:      leave = armed && !line_hi;
            START_LOW: leave = line_hi;
            default:   leave = phase_done;
         endcase
      end
   end

   // Microsecond counter; saturates while measuring the host start pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         us_cnt <= '0;
      else if (leave)
         us_cnt <= '0;
      else if (tick && !(state == START_LOW && us_cnt == START_MIN_C))
         us_cnt <= us_cnt + 1'b1;
   end

   // Protocol FSM with registered line enable, busy and frame_done
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         oe         <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         armed      <= 1'b0;
         shreg      <= '0;
         bit_idx    <= '0;
      end else begin
         frame_done <= 1'b0;
         if (!enable) begin
            state <= IDLE;
            oe    <= 1'b0;
            busy  <= 1'b0;
            armed <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  oe   <= 1'b0;
                  busy <= 1'b0;
                  // A start needs the line seen high first, so a line held
                  // low after our own frame cannot retrigger.
                  if (line_hi)
                     armed <= 1'b1;
                  else if (armed) begin
                     armed <= 1'b0;
                     state <= START_LOW;
                  end
               end
               START_LOW: begin
                  if (line_hi) begin
                     if (start_ok) begin
                        state <= WAIT_REL;
                        busy  <= 1'b1;
                        shreg <= {hum_int, hum_dec, tmp_int, tmp_dec,
                                  dht_checksum(hum_int, hum_dec, tmp_int, tmp_dec)
                                  ^ {7'd0, inject_err}};
                     end else
                        state <= IDLE;
                  end
               end
               WAIT_REL: begin
                  if (phase_done) begin
                     state <= RESP_L;
                     oe    <= 1'b1;
                  end
               end
               RESP_L: begin
                  if (phase_done) begin
                     state <= RESP_H;
                     oe    <= 1'b0;
                  end
               end
               RESP_H: begin
                  if (phase_done) begin
                     state   <= BIT_L;
                     oe      <= 1'b1;
                     bit_idx <= LAST_BIT;
                  end
               end
               BIT_L: begin
                  if (phase_done) begin
                     state <= BIT_H;
                     oe    <= 1'b0;
                  end
               end
               BIT_H: begin
                  if (phase_done) begin
                     oe    <= 1'b1;
                     shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
                     if (bit_idx == 6'd0)
                        state <= END_L;
                     else begin
                        bit_idx <= bit_idx - 1'b1;
                        state   <= BIT_L;
                     end
                  end
               end
               END_L: begin
                  if (phase_done) begin
                     state      <= IDLE;
                     oe         <= 1'b0;
                     busy       <= 1'b0;
                     frame_done <= 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
                  oe    <= 1'b0;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire
